board_io_conditioner: RTL and testbench
=======================================

// Module: board_io_conditioner
// PURPOSE
//  Board-level input conditioning between FPGA pins and top_game: N_SYNC-channel multi-flop synchroniser
//  (PS2Clk, PS2Data, UART rx), N_BTN-channel debouncer with edge pulses, and system reset sequencer
//  gated by clock-wizard locked. Sits in the FPGA top beside clk_wiz_65, in the 65 MHz domain.
//  Generalises the pin-to-core hookup: width/depth parametrised, adds debounce, edge detect, reset hold.
// PARAMETERS
//  N_SYNC           3        number of plain-synchronised async inputs
//  SYNC_STAGES      2        flops per synchroniser chain (legal 2..4)
//  SYNC_RST_VAL     '1       N_SYNC-bit reset value of sync chains/sync_out (PS2/UART idle high)
//  N_BTN            1        number of debounced button inputs
//  DEBOUNCE_CYCLES  650_000  consecutive stable cycles before level change (10 ms @ 65 MHz), >=1
//  RST_HOLD_CYCLES  1024     consecutive synchronised-locked cycles before rst_sys deasserts, >=1
// PORTS
//  clk          in   1       65 MHz system clock
//  rst          in   1       asynchronous, active-high reset
//  locked       in   1       clock-wizard locked, asynchronous
//  async_in     in   N_SYNC  raw pins
//  sync_out     out  N_SYNC  synchronised pins
//  btn_in       in   N_BTN   raw buttons, active high
//  btn_level    out  N_BTN   debounced level
//  btn_press    out  N_BTN   1-cycle pulse on debounced 0->1
//  btn_release  out  N_BTN   1-cycle pulse on debounced 1->0
//  rst_sys      out  1       reset for top_game, active high
//  ready        out  1       ~rst_sys, registered
// BEHAVIOUR
//  Reset (rst=1, async): sync chains/sync_out=SYNC_RST_VAL, btn chains/btn_level/press/release=0,
//   debounce counters=0, locked chain=0, hold counter=0, rst_sys=1, ready=0.
//  Sync: sync_out[i] = async_in[i] delayed SYNC_STAGES clk edges; no other logic.
//  Debounce per channel: btn_in through SYNC_STAGES chain -> s. If s==btn_level, cnt<=0.
//   Else cnt++; when cnt reaches DEBOUNCE_CYCLES-1 on a cycle with s!=btn_level: btn_level<=s, cnt<=0,
//   btn_press (s=1) or btn_release (s=0) high for that one cycle. Any return of s to btn_level
//   before then clears cnt (bounce). Latency pin->level = SYNC_STAGES+DEBOUNCE_CYCLES edges.
//   Counter width $clog2(DEBOUNCE_CYCLES+1); no wrap possible. press and release never both high.
//  Reset sequencer, states HOLD / RUN:
//   locked through 2-flop chain -> lk. HOLD: rst_sys=1; lk=1 -> hold_cnt++; lk=0 -> hold_cnt<=0;
//   hold_cnt==RST_HOLD_CYCLES-1 with lk=1 -> RUN, rst_sys<=0 (synchronous deassert).
//   RUN: rst_sys=0; lk=0 -> HOLD, rst_sys<=1 next edge, hold_cnt<=0.
//   ready = registered ~rst_sys (one edge after rst_sys).
//  Mid-operation: locked drop in RUN re-enters HOLD; debouncers/sync chains keep running (rst only).
//   rst during HOLD or RUN -> immediate full reset, sequence restarts from locked.
//  rst_sys never glitches low: driven only from the state flop.
// STRUCTURE
//  board_io_pkg: default constants (CLK_HZ=65_000_000, DEBOUNCE_10MS, RST_HOLD_DEFAULT), rst_state_t
//   enum {HOLD, RUN}.
//  Sub-module io_debounce (one channel: sync chain, counter, level, press/release), generate-instanced
//   N_BTN times; sync chains and reset sequencer inline.
// TESTING (bench params: N_SYNC=3, SYNC_STAGES=2, N_BTN=2, DEBOUNCE_CYCLES=4, RST_HOLD_CYCLES=8)
//  1 rst=1, then 0 with locked=1 from t0 -> rst_sys=1 for 2+8 edges, falls on edge 10; ready on edge 11.
//  2 async_in 3'b111->3'b010 on one edge -> sync_out=3'b010 exactly 2 edges later; reset value 3'b111.
//  3 btn_in[0]=1 steady -> btn_level[0]=1 and btn_press[0]=1 for 1 cycle, 6 edges after change; [1] stays 0.
//  4 btn_in[0] bounce 1,1,1,0,1,1,1,1 (per cycle) -> no press until 4 stable synced cycles after last 0.
//  5 in RUN, locked=0 for 1 cycle -> rst_sys=1 within 3 edges, held; relock -> deasserts 10 edges later.
//  6 rst pulse mid-debounce (cnt=2) -> all outputs at reset values asynchronously, counter restarts at 0.

Source files
------------

// File: rtl/board_io_pkg.sv
// Shared constants and types for the board-level input conditioner.
package board_io_pkg;

  localparam int CLK_HZ           = 65_000_000;
  localparam int DEBOUNCE_10MS    = CLK_HZ / 100;
  localparam int RST_HOLD_DEFAULT = 1024;

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } rst_state_t;

endpackage

// File: rtl/io_debounce.sv
// One button channel: multi-flop synchroniser, stability counter,
// debounced level and single-cycle rise/fall pulses.
module io_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int              CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   TC = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // Bring the raw pin into the clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
  end

  // Count consecutive cycles of disagreement; any agreement (bounce) restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (s == level) begin
        cnt <= '0;
      end else if (cnt == TC) begin
        level <= s;
        cnt   <= '0;
        rise  <= s;
        fall  <= ~s;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/board_io_conditioner.sv
// Pin-to-core conditioning: plain synchronisers, debounced buttons and a
// locked-gated system reset sequencer.
//
//   state | meaning
//   HOLD  | rst_sys asserted; counting consecutive synchronised-locked cycles
//   RUN   | rst_sys released; any loss of lock returns to HOLD
module board_io_conditioner
  import board_io_pkg::*;
#(
  parameter int                N_SYNC          = 3,
  parameter int                SYNC_STAGES     = 2,
  parameter logic [N_SYNC-1:0] SYNC_RST_VAL    = '1,
  parameter int                N_BTN           = 1,
  parameter int                DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int                RST_HOLD_CYCLES = RST_HOLD_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              locked,
  input  logic [N_SYNC-1:0] async_in,
  output logic [N_SYNC-1:0] sync_out,
  input  logic [N_BTN-1:0]  btn_in,
  output logic [N_BTN-1:0]  btn_level,
  output logic [N_BTN-1:0]  btn_press,
  output logic [N_BTN-1:0]  btn_release,
  output logic              rst_sys,
  output logic              ready
);

  localparam int            HW      = $clog2(RST_HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_TC = HW'(RST_HOLD_CYCLES - 1);

  logic [N_SYNC-1:0] sync_q [SYNC_STAGES];
  logic [1:0]        lk_q;
  logic              lk;
  rst_state_t        state, next_state;
  logic [HW-1:0]     hold_cnt, next_cnt;

  // Plain synchroniser chains; idle-high reset suits PS/2 and UART lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST_VAL;
    end else begin
      sync_q[0] <= async_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    io_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk   (clk),
      .rst   (rst),
      .btn_in(btn_in[g]),
      .level (btn_level[g]),
      .rise  (btn_press[g]),
      .fall  (btn_release[g])
    );
  end

  // The clock wizard's locked flag is asynchronous to clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lk_q <= '0;
    else     lk_q <= {lk_q[0], locked};
  end

  assign lk = lk_q[1];

  // Sequencer state and hold counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= HOLD;
      hold_cnt <= '0;
    end else begin
      state    <= next_state;
      hold_cnt <= next_cnt;
    end
  end

  // Release only after an unbroken run of locked cycles; drop back on any loss.
  always_comb begin
    next_state = state;
    next_cnt   = hold_cnt;
    case (state)
      HOLD: begin
        if (!lk) begin
          next_cnt = '0;
        end else if (hold_cnt == HOLD_TC) begin
          next_state = RUN;
          next_cnt   = '0;
        end else begin
          next_cnt = hold_cnt + 1'b1;
        end
      end
      RUN: begin
        if (!lk) begin
          next_state = HOLD;
          next_cnt   = '0;
        end
      end
    endcase
  end

  // rst_sys comes straight off the state flop so it cannot glitch.
  assign rst_sys = (state == HOLD);

  // ready trails rst_sys by one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ready <= 1'b0;
    else     ready <= ~rst_sys;
  end

endmodule

// File: tb/tb_board_io_conditioner.sv
// Bench for board_io_conditioner: hand-written vector table, corner-case
// sequences and randomized traffic against a sliding-window reference model.
module tb_board_io_conditioner;

  localparam int NS = 3;
  localparam int NB = 2;
  localparam int DB = 4;
  localparam int RH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          locked;
  logic [NS-1:0] async_in, sync_out;
  logic [NB-1:0] btn_in, btn_level, btn_press, btn_release;
  logic          rst_sys, ready;

  int n_pass  = 0;
  int n_total = 0;

  board_io_conditioner #(
    .N_SYNC         (NS),
    .SYNC_STAGES    (2),
    .SYNC_RST_VAL   (3'b111),
    .N_BTN          (NB),
    .DEBOUNCE_CYCLES(DB),
    .RST_HOLD_CYCLES(RH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .locked     (locked),
    .async_in   (async_in),
    .sync_out   (sync_out),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .rst_sys    (rst_sys),
    .ready      (ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: pin delays plus "last N samples all disagree" windows.
  logic [NS-1:0] m_a1, m_sync;
  logic [NB-1:0] m_b1, m_s, m_level, m_press, m_rel;
  logic [DB-1:0] m_win [NB];
  logic [RH-1:0] m_lkwin;
  logic          m_l1, m_lk, m_rst_sys, m_ready;

  task automatic model_reset();
    m_a1 = 3'b111; m_sync = 3'b111;
    m_b1 = '0; m_s = '0; m_level = '0; m_press = '0; m_rel = '0;
    for (int c = 0; c < NB; c++) m_win[c] = '0;
    m_lkwin = '0; m_l1 = 1'b0; m_lk = 1'b0; m_rst_sys = 1'b1; m_ready = 1'b0;
  endtask

  task automatic model_edge();
    m_ready   = !m_rst_sys;
    m_lkwin   = {m_lkwin[RH-2:0], m_lk};
    m_rst_sys = !(&m_lkwin);
    m_lk      = m_l1;
    m_l1      = locked;
    m_sync    = m_a1;
    m_a1      = async_in;
    for (int c = 0; c < NB; c++) begin
      m_win[c]   = {m_win[c][DB-2:0], m_s[c]};
      m_press[c] = 1'b0;
      m_rel[c]   = 1'b0;
      if (m_win[c] == {DB{~m_level[c]}}) begin
        m_level[c] = ~m_level[c];
        m_press[c] = m_level[c];
        m_rel[c]   = ~m_level[c];
      end
    end
    m_s  = m_b1;
    m_b1 = btn_in;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".sync_out"}, sync_out, m_sync);
    check({tag, ".btn_level"}, btn_level, m_level);
    check({tag, ".btn_press"}, btn_press, m_press);
    check({tag, ".btn_release"}, btn_release, m_rel);
    check({tag, ".rst_sys"}, rst_sys, m_rst_sys);
    check({tag, ".ready"}, ready, m_ready);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".sync_out"}, sync_out, 3'b111);
    check({tag, ".btn_level"}, btn_level, 2'b00);
    check({tag, ".btn_press"}, btn_press, 2'b00);
    check({tag, ".btn_release"}, btn_release, 2'b00);
    check({tag, ".rst_sys"}, rst_sys, 1'b1);
    check({tag, ".ready"}, ready, 1'b0);
  endtask

  typedef struct {
    logic [NS-1:0] a;
    logic [NB-1:0] b;
    logic [NS-1:0] sync;
    logic [NB-1:0] lvl;
    logic [NB-1:0] prs;
    logic          rs;
    logic          rdy;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int            first, first_hi, first_lo;
    logic [7:0]    bounce;

    // Expected outputs after each of the first 12 edges following reset release.
    tbl[0]  = '{3'b111, 2'b01, 3'b111, 2'b00, 2'b00, 1'b1, 1'b0};
    tbl[1]  = '{3'b010, 2'b01, 3'b111, 2'b00, 2'b00, 1'b1, 1'b0};
    tbl[2]  = '{3'b010, 2'b01, 3'b010, 2'b00, 2'b00, 1'b1, 1'b0};
    tbl[3]  = '{3'b101, 2'b01, 3'b010, 2'b00, 2'b00, 1'b1, 1'b0};
    tbl[4]  = '{3'b101, 2'b01, 3'b101, 2'b00, 2'b00, 1'b1, 1'b0};
    tbl[5]  = '{3'b000, 2'b01, 3'b101, 2'b01, 2'b01, 1'b1, 1'b0};
    tbl[6]  = '{3'b000, 2'b01, 3'b000, 2'b01, 2'b00, 1'b1, 1'b0};
    tbl[7]  = '{3'b110, 2'b01, 3'b000, 2'b01, 2'b00, 1'b1, 1'b0};
    tbl[8]  = '{3'b110, 2'b01, 3'b110, 2'b01, 2'b00, 1'b1, 1'b0};
    tbl[9]  = '{3'b110, 2'b01, 3'b110, 2'b01, 2'b00, 1'b0, 1'b0};
    tbl[10] = '{3'b110, 2'b01, 3'b110, 2'b01, 2'b00, 1'b0, 1'b1};
    tbl[11] = '{3'b110, 2'b01, 3'b110, 2'b01, 2'b00, 1'b0, 1'b1};

    rst = 1'b1; locked = 1'b0; async_in = 3'b111; btn_in = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values("reset");

    // Reset release with locked already high; sync, debounce and hold timing.
    rst = 1'b0; locked = 1'b1;
    for (int k = 0; k < 12; k++) begin
      async_in = tbl[k].a;
      btn_in   = tbl[k].b;
      step();
      check($sformatf("tbl%0d.sync_out", k), sync_out, tbl[k].sync);
      check($sformatf("tbl%0d.btn_level", k), btn_level, tbl[k].lvl);
      check($sformatf("tbl%0d.btn_press", k), btn_press, tbl[k].prs);
      check($sformatf("tbl%0d.btn_release", k), btn_release, 2'b00);
      check($sformatf("tbl%0d.rst_sys", k), rst_sys, tbl[k].rs);
      check($sformatf("tbl%0d.ready", k), ready, tbl[k].rdy);
    end

    // Bounce on button 1: 1,1,1,0 then steady 1; press only after 4 clean synced cycles.
    bounce = 8'b1111_0111;
    first  = 0;
    for (int n = 1; n <= 16; n++) begin
      btn_in[1] = (n <= 8) ? bounce[n-1] : 1'b1;
      step();
      compare_model("bounce");
      if (btn_press[1] && first == 0) first = n;
    end
    check("bounce.press_step", first, 10);
    check("bounce.level", btn_level, 2'b11);

    // One-cycle lock loss while running.
    first_hi = 0; first_lo = 0;
    for (int n = 1; n <= 14; n++) begin
      locked = (n == 1) ? 1'b0 : 1'b1;
      step();
      compare_model("relock");
      if (rst_sys && first_hi == 0) first_hi = n;
      if (!rst_sys && first_hi != 0 && first_lo == 0) first_lo = n;
    end
    check("relock.assert_step", first_hi, 3);
    check("relock.release_step", first_lo, 11);

    // Async reset in the middle of a debounce count.
    btn_in[1] = 1'b0;
    repeat (4) begin
      step();
      compare_model("middeb");
    end
    check("middeb.level_held", btn_level[1], 1'b1);
    #2 rst = 1'b1;
    #1 check_reset_values("midrst");
    model_reset();
    @(negedge clk);
    rst = 1'b0; btn_in = 2'b10;
    first = 0;
    for (int n = 1; n <= 10; n++) begin
      step();
      compare_model("restart");
      if (btn_level[1] && first == 0) first = n;
    end
    check("restart.level_step", first, 6);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      async_in = NS'($urandom);
      for (int c = 0; c < NB; c++)
        if ($urandom_range(5) == 0) btn_in[c] = ~btn_in[c];
      if (locked) locked = ($urandom_range(39) != 0);
      else        locked = ($urandom_range(2) == 0);
      step();
      compare_model("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
